switch_allocator: RTL

Per-router switch allocator for the 2x2 mesh wormhole router. It takes the one-hot output-port requests that route compute produces for each of the five input ports (L, E, N, W, S). Each output port gets a round-robin winner, held for the whole packet from header to tail. The allocator drives the crossbar select and the input dequeue strobes, and gates every transfer on downstream credits.

---
 rtl/switch_allocator_if.sv | 26 ++
 rtl/switch_allocator.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/switch_allocator_if.sv
// Request/grant/credit bundle between the input buffers, the switch allocator and the crossbar.
// The master drives requests and credits; the slave is the allocator.
interface switch_allocator_if #(
    parameter int unsigned NUM_PORTS = 5
);
    localparam int unsigned IW = $clog2(NUM_PORTS + 1);

    logic [NUM_PORTS-1:0]           in_valid;
    logic [NUM_PORTS*NUM_PORTS-1:0] in_req;
    logic [NUM_PORTS-1:0]           in_tail;
    logic [NUM_PORTS-1:0]           in_grant;
    logic [NUM_PORTS*IW-1:0]        out_sel;
    logic [NUM_PORTS-1:0]           out_valid;
    logic [NUM_PORTS-1:0]           credit_in;
    logic                           credit_err;

    modport master (
        output in_valid, in_req, in_tail, credit_in,
        input  in_grant, out_sel, out_valid, credit_err
    );

    modport slave (
        input  in_valid, in_req, in_tail, credit_in,
        output in_grant, out_sel, out_valid, credit_err
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-router switch allocator: round-robin per output, locked from header to tail.
// Define SWITCH_ALLOC_CREDIT_EN to build downstream credit counters, gating and credit_err.
module switch_allocator #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CW        = 3
) (
    input logic               clk,
    input logic               rst,
    switch_allocator_if.slave bus
);
    localparam int unsigned IW = $clog2(NUM_PORTS + 1);

    logic [NUM_PORTS-1:0] lock_q, lock_d;
    logic [IW-1:0]        owner_q [NUM_PORTS];
    logic [IW-1:0]        owner_d [NUM_PORTS];
    logic [IW-1:0]        rr_ptr_q [NUM_PORTS];
    logic [IW-1:0]        rr_ptr_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] req_oh [NUM_PORTS];
    logic [NUM_PORTS-1:0] elig [NUM_PORTS];
    logic [NUM_PORTS-1:0] cred_ok;
    logic [NUM_PORTS-1:0] out_grant;
    logic [IW-1:0]        winner [NUM_PORTS];

    // Illegal multi-hot requests resolve to the lowest set bit.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_oh[i] = '0;
            for (int o = NUM_PORTS - 1; o >= 0; o--) begin
                if (bus.in_req[NUM_PORTS*i + o]) begin
                    req_oh[i]    = '0;
                    req_oh[i][o] = 1'b1;
                end
            end
        end
    end

    always_comb begin : arb
        int idx;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_grant[o] = 1'b0;
            winner[o]    = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                elig[o][i] = bus.in_valid[i] & req_oh[i][o] & cred_ok[o];
            end
            if (lock_q[o]) begin
                if (elig[o][owner_q[o]]) begin
                    out_grant[o] = 1'b1;
                    winner[o]    = owner_q[o];
                end
            end else begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(rr_ptr_q[o]) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (!out_grant[o] && elig[o][idx]) begin
                        out_grant[o] = 1'b1;
                        winner[o]    = IW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.in_grant  = '0;
        bus.out_sel   = '0;
        bus.out_valid = out_grant;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (out_grant[o]) begin
                bus.out_sel[IW*o +: IW] = winner[o] + IW'(1);
                bus.in_grant[winner[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            owner_d[o]  = owner_q[o];
            rr_ptr_d[o] = rr_ptr_q[o];
            if (out_grant[o]) begin
                if (lock_q[o]) begin
                    if (bus.in_tail[winner[o]]) lock_d[o] = 1'b0;
                end else begin
                    rr_ptr_d[o] = (winner[o] == IW'(NUM_PORTS - 1)) ? '0 : winner[o] + IW'(1);
                    if (!bus.in_tail[winner[o]]) begin
                        lock_d[o]  = 1'b1;
                        owner_d[o] = winner[o];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
        end else begin
            lock_q <= lock_d;
            for (int o = 0; o < NUM_PORTS; o++) begin
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
            end
        end
    end

`ifdef SWITCH_ALLOC_CREDIT_EN
    logic [CW-1:0] cred_q [NUM_PORTS];
    logic [CW-1:0] cred_d [NUM_PORTS];
    logic          credit_err_q, credit_err_d;

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) cred_ok[o] = (cred_q[o] != '0);
    end

    // A grant and a returning credit in the same cycle cancel out.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            cred_d[o] = cred_q[o];
            if (out_grant[o] && !bus.credit_in[o]) begin
                cred_d[o] = cred_q[o] - CW'(1);
            end else if (!out_grant[o] && bus.credit_in[o]) begin
                if (cred_q[o] == CW'(BUF_DEPTH)) credit_err_d = 1'b1;
                else                             cred_d[o] = cred_q[o] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err_q <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) cred_q[o] <= CW'(BUF_DEPTH);
        end else begin
            credit_err_q <= credit_err_d;
            for (int o = 0; o < NUM_PORTS; o++) cred_q[o] <= cred_d[o];
        end
    end

    assign bus.credit_err = credit_err_q;
`else
    logic unused_credit;
    assign unused_credit  = ^bus.credit_in;
    assign cred_ok        = '1;
    assign bus.credit_err = 1'b0;
`endif
endmodule
